// File: rtl/swd_dp_target.sv
// SW-DP target front end: oversampled SWD slave holding DP registers and issuing MEM-AP requests.
// Latency: SYNC_STAGES+1 clk_i from pad SWCLK rise to protocol event; SWDIO drive updates one clk_i later.
// Backpressure: AP/RDBUFF accesses answer WAIT while ap_req_o is outstanding; ap_req_o holds until ap_ack_i.
//
// Ports:
//   clk_i, rst_i                    system clock (>= 4x SWCLK), async active-high reset
//   swclk_i, swdio_i                asynchronous pad inputs
//   swdio_o, swdio_oen_o            SWDIO drive value / release (1 = host drives)
//   swd_active_o                    JTAG-to-SWD select sequence seen
//   ap_req_o .. ap_ack_i            MEM-AP request/acknowledge port
//   c*pwrupreq_o, c*pwrupack_i      power-up handshake, reflected in CTRL/STAT
module swd_dp_target #(
  parameter logic [31:0] IDCODE      = 32'h2BA01477,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        swclk_i,
  input  logic        swdio_i,
  output logic        swdio_o,
  output logic        swdio_oen_o,
  output logic        swd_active_o,
  output logic        ap_req_o,
  output logic        ap_wr_o,
  output logic [7:0]  ap_addr_o,
  output logic [31:0] ap_wdata_o,
  input  logic [31:0] ap_rdata_i,
  input  logic        ap_ack_i,
  output logic        cdbgpwrupreq_o,
  output logic        csyspwrupreq_o,
  input  logic        cdbgpwrupack_i,
  input  logic        csyspwrupack_i
);

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  typedef enum logic [3:0] {
    S_SEEK, S_IDLE, S_HDR, S_TRN1, S_ACK, S_RDATA, S_TRN2, S_WTRN, S_WDATA
  } state_t;

  state_t state, state_nxt;

  // Pad synchronizers and SWCLK rising-edge event
  logic [SYNC_STAGES-1:0] clk_sync, dio_sync;
  logic                   clk_prev, ev, sbit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync <= '0;
      dio_sync <= '0;
      clk_prev <= 1'b0;
      ev       <= 1'b0;
      sbit     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], swclk_i};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], swdio_i};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      ev       <= clk_sync[SYNC_STAGES-1] & ~clk_prev;
      sbit     <= dio_sync[SYNC_STAGES-1];
    end
  end

  // Protocol datapath state
  logic [5:0]  cnt, ones_cnt;
  logic [15:0] sr16;
  logic [5:0]  hdr;        // {stop, parity, A3, A2, RnW, APnDP}
  logic [2:0]  ack_r;
  logic [31:0] rsh, wsh, rdbuff;
  logic [3:0]  apbank;
  logic        lr_seen, zero_seen, sticky, wderr;

  logic        apndp, rnw, hdr_ok, line_rst, seq_match, sel_done;
  logic        err, exempt, ap_path, wpar_ok;
  logic [1:0]  a;
  logic [2:0]  ack_sel;
  logic [31:0] ctrl_stat, rd_val;

  assign apndp = hdr[0];
  assign rnw   = hdr[1];
  assign a     = hdr[3:2];

  // Evaluated on the park-bit event: sbit is the park bit itself
  assign hdr_ok    = (hdr[4] == ^hdr[3:0]) && !hdr[5] && sbit;
  // ones_cnt counts ones before this event, so >=49 makes this the 50th
  assign line_rst  = ev && sbit && (ones_cnt >= 6'd49);
  assign seq_match = ({sbit, sr16[15:1]} == 16'hE79E);
  // Second consecutive low bit after a line reset that followed selection
  assign sel_done  = swd_active_o && lr_seen && zero_seen && !sbit;
  assign wpar_ok   = (sbit == ^wsh);

  // Error flags must stay recoverable: IDCODE/CTRL reads and ABORT always go through
  assign err     = sticky | wderr;
  assign exempt  = !apndp && (rnw ? (a <= 2'd1) : (a == 2'd0));
  assign ap_path = apndp || (rnw && (a == 2'd3));

  always_comb begin
    ack_sel = ACK_OK;
    if (err && !exempt)
      ack_sel = ACK_FAULT;
    else if (ap_path && ap_req_o)
      ack_sel = ACK_WAIT;
  end

  assign ctrl_stat = {csyspwrupack_i, csyspwrupreq_o, cdbgpwrupack_i, cdbgpwrupreq_o,
                      20'h0, wderr, 1'b0, sticky, 5'h0};

  always_comb begin
    rd_val = rdbuff;
    if (!apndp) begin
      case (a)
        2'd0:    rd_val = IDCODE;
        2'd1:    rd_val = ctrl_stat;
        2'd2:    rd_val = 32'h0;
        default: rd_val = rdbuff;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_SEEK;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (ev) begin
      if (line_rst) begin
        state_nxt = S_SEEK;
      end else begin
        case (state)
          S_SEEK:  if (sel_done) state_nxt = S_IDLE;
          S_IDLE:  if (sbit) state_nxt = S_HDR;
          S_HDR:   if (cnt == 6'd6) state_nxt = hdr_ok ? S_TRN1 : S_IDLE;
          S_TRN1:  state_nxt = S_ACK;
          S_ACK:   if (cnt == 6'd2)
                     state_nxt = (ack_r != ACK_OK) ? S_TRN2 : (rnw ? S_RDATA : S_WTRN);
          S_RDATA: if (cnt == 6'd32) state_nxt = S_TRN2;
          S_TRN2:  state_nxt = S_IDLE;
          S_WTRN:  state_nxt = S_WDATA;
          S_WDATA: if (cnt == 6'd32) state_nxt = S_IDLE;
          default: state_nxt = S_SEEK;
        endcase
      end
    end
  end

  // FSM: outputs (target drives only during ACK and read data)
  always_comb begin
    swdio_o     = 1'b0;
    swdio_oen_o = 1'b1;
    case (state)
      S_ACK: begin
        swdio_oen_o = 1'b0;
        swdio_o     = (cnt[1:0] == 2'd0) ? ack_r[0] :
                      (cnt[1:0] == 2'd1) ? ack_r[1] : ack_r[2];
      end
      S_RDATA: begin
        swdio_oen_o = 1'b0;
        swdio_o     = cnt[5] ? ^rsh : rsh[cnt[4:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt            <= '0;
      ones_cnt       <= '0;
      sr16           <= '0;
      hdr            <= '0;
      ack_r          <= '0;
      rsh            <= '0;
      wsh            <= '0;
      rdbuff         <= '0;
      apbank         <= '0;
      lr_seen        <= 1'b0;
      zero_seen      <= 1'b0;
      sticky         <= 1'b0;
      wderr          <= 1'b0;
      swd_active_o   <= 1'b0;
      ap_req_o       <= 1'b0;
      ap_wr_o        <= 1'b0;
      ap_addr_o      <= '0;
      ap_wdata_o     <= '0;
      cdbgpwrupreq_o <= 1'b0;
      csyspwrupreq_o <= 1'b0;
    end else begin
      // A new request is only issued with ap_req_o low, so this never races it
      if (ap_ack_i && ap_req_o) begin
        ap_req_o <= 1'b0;
        if (!ap_wr_o) rdbuff <= ap_rdata_i;
      end
      if (ev) begin
        cnt      <= (state_nxt != state) ? 6'd0 : cnt + 6'd1;
        ones_cnt <= !sbit ? 6'd0 : (ones_cnt == 6'd50) ? ones_cnt : ones_cnt + 6'd1;
        if (state == S_SEEK) sr16 <= {sbit, sr16[15:1]};
        if (line_rst) begin
          apbank    <= '0;
          lr_seen   <= 1'b1;
          zero_seen <= 1'b0;
        end else begin
          case (state)
            S_SEEK: begin
              zero_seen <= !sbit;
              if (seq_match) begin
                swd_active_o <= 1'b1;
                lr_seen      <= 1'b0;
              end
              if (sel_done) begin
                lr_seen   <= 1'b0;
                zero_seen <= 1'b0;
              end
            end
            S_HDR: if (cnt != 6'd6) hdr <= {sbit, hdr[5:1]};
            S_TRN1: ack_r <= ack_sel;
            S_ACK: begin
              // AP reads are posted: return the old RDBUFF, fetch the new value now
              if (cnt == 6'd2 && ack_r == ACK_OK && rnw) begin
                rsh <= rd_val;
                if (apndp) begin
                  ap_req_o  <= 1'b1;
                  ap_wr_o   <= 1'b0;
                  ap_addr_o <= {apbank, a, 2'b00};
                end
              end
            end
            S_WDATA: begin
              if (!cnt[5]) begin
                wsh <= {sbit, wsh[31:1]};
              end else if (!wpar_ok) begin
                wderr <= 1'b1;
              end else if (apndp) begin
                ap_req_o   <= 1'b1;
                ap_wr_o    <= 1'b1;
                ap_addr_o  <= {apbank, a, 2'b00};
                ap_wdata_o <= wsh;
              end else begin
                case (a)
                  2'd0: begin
                    if (wsh[2]) sticky <= 1'b0;
                    if (wsh[3]) wderr  <= 1'b0;
                  end
                  2'd1: begin
                    csyspwrupreq_o <= wsh[30];
                    cdbgpwrupreq_o <= wsh[28];
                  end
                  2'd2:    apbank <= wsh[7:4];
                  default: ;
                endcase
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_swd_dp_target.sv
// Bench for swd_dp_target: SWD host driver, DP/AP register model and AP responder.
// Latency: host SWCLK period is 16 clk_i; target drive is sampled just before each rising SWCLK.
// Backpressure: AP acknowledge is issued by hand, so WAIT windows are controlled directly.
module tb_swd_dp_target;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        swclk_i = 1'b0;
  logic        host_bit = 1'b1;
  logic        swdio_i;
  logic        swdio_o, swdio_oen_o, swd_active_o;
  logic        ap_req_o, ap_wr_o;
  logic [7:0]  ap_addr_o;
  logic [31:0] ap_wdata_o;
  logic [31:0] ap_rdata_i = 32'h0;
  logic        ap_ack_i = 1'b0;
  logic        cdbgpwrupreq_o, csyspwrupreq_o;
  logic        cdbgpwrupack_i = 1'b1;
  logic        csyspwrupack_i = 1'b1;

  // Shared line: pull-up/host value when released, target value when driven
  assign swdio_i = swdio_oen_o ? host_bit : swdio_o;

  swd_dp_target dut (
    .clk_i(clk_i), .rst_i(rst_i), .swclk_i(swclk_i), .swdio_i(swdio_i),
    .swdio_o(swdio_o), .swdio_oen_o(swdio_oen_o), .swd_active_o(swd_active_o),
    .ap_req_o(ap_req_o), .ap_wr_o(ap_wr_o), .ap_addr_o(ap_addr_o),
    .ap_wdata_o(ap_wdata_o), .ap_rdata_i(ap_rdata_i), .ap_ack_i(ap_ack_i),
    .cdbgpwrupreq_o(cdbgpwrupreq_o), .csyspwrupreq_o(csyspwrupreq_o),
    .cdbgpwrupack_i(cdbgpwrupack_i), .csyspwrupack_i(csyspwrupack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Register model
  logic        m_active = 0, m_sticky = 0, m_wderr = 0, m_dbgreq = 0, m_sysreq = 0;
  logic [31:0] m_sel = 0, m_rdbuff = 0;
  logic        m_apreq = 0, m_apwr = 0;
  logic [7:0]  m_apaddr = 0;
  logic [31:0] m_apwdata = 0;
  logic        chk_en = 0;

  logic [2:0]  last_ack;
  logic [31:0] last_rd;
  logic        last_rp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Steady-state outputs between transactions
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("oen_idle", swdio_oen_o, 1'b1);
      chk("swd_active", swd_active_o, m_active);
      chk("ap_req", ap_req_o, m_apreq);
      chk("cdbgpwrupreq", cdbgpwrupreq_o, m_dbgreq);
      chk("csyspwrupreq", csyspwrupreq_o, m_sysreq);
      if (m_apreq) begin
        chk("ap_wr", ap_wr_o, m_apwr);
        chk("ap_addr", ap_addr_o, m_apaddr);
        if (m_apwr) chk("ap_wdata", ap_wdata_o, m_apwdata);
      end
    end
  end

  function automatic logic [2:0] exp_ack(input logic apndp, input logic rnw, input logic [1:0] a);
    logic exempt;
    exempt = !apndp && (rnw ? (a <= 2'd1) : (a == 2'd0));
    if ((m_sticky || m_wderr) && !exempt) return 3'b100;
    if ((apndp || (rnw && a == 2'd3)) && m_apreq) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [31:0] exp_rd(input logic apndp, input logic [1:0] a);
    if (apndp || a == 2'd3) return m_rdbuff;
    if (a == 2'd0) return 32'h2BA01477;
    if (a == 2'd1)
      return {csyspwrupack_i, m_sysreq, cdbgpwrupack_i, m_dbgreq, 20'h0, m_wderr, 1'b0, m_sticky, 5'h0};
    return 32'h0;
  endfunction

  task automatic swd_cycle(input logic b, output logic s);
    swclk_i  = 1'b0;
    host_bit = b;
    #80;
    s = swdio_i;
    swclk_i = 1'b1;
    #80;
  endtask

  task automatic send(input logic b);
    logic s;
    swd_cycle(b, s);
  endtask

  task automatic send_hdr(input logic apndp, input logic rnw, input logic [1:0] a, input logic bad);
    send(1'b1); send(apndp); send(rnw); send(a[0]); send(a[1]);
    send(apndp ^ rnw ^ a[0] ^ a[1] ^ bad); send(1'b0); send(1'b1);
  endtask

  task automatic xfer(input logic apndp, input logic rnw, input logic [1:0] a, input logic [31:0] wd,
                      input logic bad, output logic [2:0] ack, output logic [31:0] rd, output logic rp);
    logic s;
    send_hdr(apndp, rnw, a, 1'b0);
    send(1'b1);
    for (int i = 0; i < 3; i++) begin swd_cycle(1'b1, s); ack[i] = s; end
    rd = '0;
    rp = 1'b0;
    if (ack == 3'b001 && rnw) begin
      for (int i = 0; i < 32; i++) begin swd_cycle(1'b1, s); rd[i] = s; end
      swd_cycle(1'b1, s);
      rp = s;
      send(1'b1);
    end else if (ack == 3'b001) begin
      send(1'b1);
      for (int i = 0; i < 32; i++) send(wd[i]);
      send(^wd ^ bad);
    end else begin
      send(1'b1);
    end
  endtask

  task automatic idle_check(input int n);
    send(1'b0);
    chk_en = 1'b1;
    repeat (n) send(1'b0);
    chk_en = 1'b0;
  endtask

  task automatic do_xfer(input string name, input logic apndp, input logic rnw, input logic [1:0] a,
                         input logic [31:0] wd, input logic bad);
    logic [2:0]  eack;
    logic [31:0] erd;
    eack = exp_ack(apndp, rnw, a);
    erd  = exp_rd(apndp, a);
    xfer(apndp, rnw, a, wd, bad, last_ack, last_rd, last_rp);
    chk({name, " ack"}, last_ack, eack);
    if (eack == 3'b001) begin
      if (rnw) begin
        chk({name, " rdata"}, last_rd, erd);
        chk({name, " rparity"}, last_rp, ^erd);
        if (apndp) begin
          m_apreq = 1; m_apwr = 0; m_apaddr = {m_sel[7:4], a, 2'b00};
        end
      end else if (bad) begin
        m_wderr = 1;
      end else if (apndp) begin
        m_apreq = 1; m_apwr = 1; m_apaddr = {m_sel[7:4], a, 2'b00}; m_apwdata = wd;
      end else begin
        case (a)
          2'd0: begin
            if (wd[2]) m_sticky = 0;
            if (wd[3]) m_wderr = 0;
          end
          2'd1: begin m_sysreq = wd[30]; m_dbgreq = wd[28]; end
          2'd2: m_sel = wd;
          default: ;
        endcase
      end
    end
    idle_check(3);
  endtask

  task automatic ap_complete(input logic [31:0] d);
    int n;
    n = 0;
    while (ap_req_o !== 1'b1 && n < 200) begin @(negedge clk_i); n++; end
    chk("ap_req before ack", ap_req_o, 1'b1);
    @(negedge clk_i);
    ap_rdata_i = d;
    ap_ack_i   = 1'b1;
    @(negedge clk_i);
    ap_ack_i   = 1'b0;
    ap_rdata_i = 32'h0;
    if (!m_apwr) m_rdbuff = d;
    m_apreq = 0;
    @(negedge clk_i);
    chk("ap_req drop", ap_req_o, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] sel_seq;
    logic [2:0]  ack;
    logic        s;
    sel_seq = 16'hE79E;

    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst swdio_o", swdio_o, 1'b0);
    chk("rst oen", swdio_oen_o, 1'b1);
    chk("rst active", swd_active_o, 1'b0);
    chk("rst ap_req", ap_req_o, 1'b0);
    chk("rst ap_wr", ap_wr_o, 1'b0);
    chk("rst ap_addr", ap_addr_o, 8'h00);
    chk("rst ap_wdata", ap_wdata_o, 32'h0);
    chk("rst pwrreq", {cdbgpwrupreq_o, csyspwrupreq_o}, 2'b00);

    // JTAG-to-SWD selection
    repeat (55) send(1'b1);
    for (int i = 0; i < 16; i++) send(sel_seq[i]);
    repeat (55) send(1'b1);
    repeat (5) send(1'b0);
    m_active = 1;
    chk("swd_active after select", swd_active_o, 1'b1);

    do_xfer("dp_rd_idcode", 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
    chk("idcode ack literal", last_ack, 3'b001);
    chk("idcode data literal", last_rd, 32'h2BA01477);
    chk("idcode parity literal", last_rp, 1'b0);

    do_xfer("dp_wr_ctrl", 1'b0, 1'b0, 2'd1, 32'h50000000, 1'b0);
    do_xfer("dp_rd_ctrl", 1'b0, 1'b1, 2'd1, 32'h0, 1'b0);
    chk("ctrl literal", last_rd, 32'hF0000000);
    chk("pwrreq literal", {cdbgpwrupreq_o, csyspwrupreq_o}, 2'b11);

    do_xfer("dp_wr_select", 1'b0, 1'b0, 2'd2, 32'h000000F0, 1'b0);
    do_xfer("ap_wr", 1'b1, 1'b0, 2'd1, 32'h20000000, 1'b0);
    chk("ap_wr addr literal", ap_addr_o, 8'hF4);
    chk("ap_wr wdata literal", ap_wdata_o, 32'h20000000);
    chk("ap_wr req literal", {ap_req_o, ap_wr_o}, 2'b11);
    idle_check(20);
    ap_complete(32'h0);

    do_xfer("ap_rd1", 1'b1, 1'b1, 2'd3, 32'h0, 1'b0);
    chk("ap_rd1 literal", last_rd, 32'h0);
    chk("ap_rd1 addr literal", ap_addr_o, 8'hFC);
    ap_complete(32'hDEADBEEF);
    do_xfer("ap_rd2", 1'b1, 1'b1, 2'd3, 32'h0, 1'b0);
    chk("ap_rd2 literal", last_rd, 32'hDEADBEEF);
    ap_complete(32'hDEADBEEF);
    do_xfer("rdbuff", 1'b0, 1'b1, 2'd3, 32'h0, 1'b0);
    chk("rdbuff literal", last_rd, 32'hDEADBEEF);

    // Stalled AP: WAIT without a data phase or a second request
    do_xfer("ap_rd3", 1'b1, 1'b1, 2'd0, 32'h0, 1'b0);
    do_xfer("ap_wr_stall", 1'b1, 1'b0, 2'd0, 32'h11111111, 1'b0);
    chk("stall ack literal", last_ack, 3'b010);
    chk("stall no new write", ap_wr_o, 1'b0);
    do_xfer("rdbuff_stall", 1'b0, 1'b1, 2'd3, 32'h0, 1'b0);
    chk("rdbuff stall literal", last_ack, 3'b010);
    ap_complete(32'hCAFEF00D);
    do_xfer("rdbuff_after", 1'b0, 1'b1, 2'd3, 32'h0, 1'b0);

    // Bad write parity, FAULT, ABORT recovery
    do_xfer("wr_badpar", 1'b0, 1'b0, 2'd2, 32'h00000010, 1'b1);
    do_xfer("ctrl_wderr", 1'b0, 1'b1, 2'd1, 32'h0, 1'b0);
    chk("wderr literal", last_rd, 32'hF0000080);
    do_xfer("ap_fault", 1'b1, 1'b1, 2'd0, 32'h0, 1'b0);
    chk("fault literal", last_ack, 3'b100);
    do_xfer("abort", 1'b0, 1'b0, 2'd0, 32'h00000008, 1'b0);
    do_xfer("ap_after_abort", 1'b1, 1'b1, 2'd0, 32'h0, 1'b0);
    chk("after abort literal", last_ack, 3'b001);
    ap_complete(32'h55AA55AA);

    // Bad header parity: target must stay released
    send_hdr(1'b0, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      swd_cycle(1'b0, s);
      chk("badhdr released", swdio_oen_o, 1'b1);
    end
    do_xfer("idcode_after_badhdr", 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);

    // Line reset clears SELECT
    repeat (55) send(1'b1);
    repeat (2) send(1'b0);
    m_sel = 32'h0;
    do_xfer("ap_wr_bank0", 1'b1, 1'b0, 2'd1, 32'hA5A5A5A5, 1'b0);
    chk("bank0 addr literal", ap_addr_o, 8'h04);
    ap_complete(32'h0);

    // Reset while the target drives read data
    send_hdr(1'b0, 1'b1, 2'd0, 1'b0);
    send(1'b1);
    for (int i = 0; i < 3; i++) begin swd_cycle(1'b1, s); ack[i] = s; end
    chk("pre-reset ack", ack, 3'b001);
    repeat (5) send(1'b1);
    chk("driving before reset", swdio_oen_o, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("reset releases swdio", swdio_oen_o, 1'b1);
    chk("reset clears active", swd_active_o, 1'b0);
    chk("reset clears pwrreq", {cdbgpwrupreq_o, csyspwrupreq_o}, 2'b00);
    chk("reset clears ap_addr", ap_addr_o, 8'h00);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
